// File: rtl/input_route_ctrl.sv
// rtl/input_route_ctrl.sv - XY route decode and per-VC wormhole lock stage
module input_route_ctrl #(
    parameter int FLIT_WIDTH  = 34,
    parameter int N_VIRT_CHN  = 2,
    parameter int X_W         = 2,
    parameter int Y_W         = 2,
    parameter int ROUTER_X_ID = 0,
    parameter int ROUTER_Y_ID = 0,
    localparam int VC_W = $clog2(N_VIRT_CHN > 1 ? N_VIRT_CHN : 2)
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [FLIT_WIDTH-1:0] fdata_i,
    input  logic [VC_W-1:0]       vc_id_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [FLIT_WIDTH-1:0] fdata_o,
    output logic [VC_W-1:0]       vc_id_o,
    output logic [4:0]            valid_o,
    input  logic [4:0]            ready_i,
    output logic                  err_o
);

    localparam logic [1:0] FT_HEAD      = 2'b00;
    localparam logic [1:0] FT_BODY      = 2'b01;
    localparam logic [1:0] FT_TAIL      = 2'b10;
    localparam logic [1:0] FT_HEAD_TAIL = 2'b11;

    localparam logic [2:0] DIR_L = 3'd0;
    localparam logic [2:0] DIR_N = 3'd1;
    localparam logic [2:0] DIR_S = 3'd2;
    localparam logic [2:0] DIR_W = 3'd3;
    localparam logic [2:0] DIR_E = 3'd4;

    localparam logic [X_W-1:0] MY_X = ROUTER_X_ID[X_W-1:0];
    localparam logic [Y_W-1:0] MY_Y = ROUTER_Y_ID[Y_W-1:0];

    logic                  out_valid;
    logic [2:0]            dir_q;
    logic [N_VIRT_CHN-1:0] lock_vld;
    logic [2:0]            lock_dir [N_VIRT_CHN];

    logic [1:0]     ftype;
    logic [X_W-1:0] x_dest;
    logic [Y_W-1:0] y_dest;
    logic [2:0]     route;
    logic           accept;
    logic           handshake;
    logic           load;
    logic [2:0]     load_dir;
    logic           proto_err;

    assign ftype  = fdata_i[FLIT_WIDTH-1:FLIT_WIDTH-2];
    assign x_dest = fdata_i[FLIT_WIDTH-3 -: X_W];
    assign y_dest = fdata_i[FLIT_WIDTH-3-X_W -: Y_W];

    // Slot is free when empty or when its occupant leaves this cycle
    assign handshake = out_valid & ready_i[dir_q];
    assign ready_o   = ~out_valid | ready_i[dir_q];
    assign accept    = valid_i & ready_o;
    assign valid_o   = out_valid ? (5'b00001 << dir_q) : 5'b00000;

    // Dimension-ordered route: resolve X first, then Y, else deliver locally
    always_comb begin
        route = DIR_L;
        if (x_dest > MY_X) begin
            route = DIR_E;
        end else if (x_dest < MY_X) begin
            route = DIR_W;
        end else if (y_dest > MY_Y) begin
            route = DIR_S;
        end else if (y_dest < MY_Y) begin
            route = DIR_N;
        end
    end

    // Decide whether the incoming flit is forwarded, where, and whether it breaks protocol
    always_comb begin
        load      = 1'b0;
        load_dir  = route;
        proto_err = 1'b0;
        case (ftype)
            FT_HEAD, FT_HEAD_TAIL: begin
                load      = 1'b1;
                proto_err = lock_vld[vc_id_i];
            end
            default: begin
                if (lock_vld[vc_id_i]) begin
                    load     = 1'b1;
                    load_dir = lock_dir[vc_id_i];
                end else begin
                    proto_err = 1'b1;
                end
            end
        endcase
    end

    // Output slot, error pulse and per-VC wormhole locks
    always_ff @(posedge clk) begin
        if (arst) begin
            out_valid <= 1'b0;
            dir_q     <= DIR_L;
            fdata_o   <= '0;
            vc_id_o   <= '0;
            err_o     <= 1'b0;
            lock_vld  <= '0;
            for (int i = 0; i < N_VIRT_CHN; i++) begin
                lock_dir[i] <= DIR_L;
            end
        end else begin
            err_o <= accept & proto_err;
            if (accept && load) begin
                out_valid <= 1'b1;
                dir_q     <= load_dir;
                fdata_o   <= fdata_i;
                vc_id_o   <= vc_id_i;
            end else if (handshake || accept) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (ftype == FT_HEAD) begin
                    lock_vld[vc_id_i] <= 1'b1;
                    lock_dir[vc_id_i] <= route;
                end else if (ftype == FT_TAIL && lock_vld[vc_id_i]) begin
                    lock_vld[vc_id_i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_input_route_ctrl.sv
// tb/tb_input_route_ctrl.sv - scoreboard bench for input_route_ctrl
module tb_input_route_ctrl;

    localparam int FW = 34;

    logic          clk = 1'b0;
    logic          arst;
    logic [FW-1:0] fdata_i;
    logic [0:0]    vc_id_i;
    logic          valid_i;
    logic          ready_o;
    logic [FW-1:0] fdata_o;
    logic [0:0]    vc_id_o;
    logic [4:0]    valid_o;
    logic [4:0]    ready_i;
    logic          err_o;

    typedef struct packed {
        logic [4:0]    v;
        logic [FW-1:0] d;
        logic [0:0]    vc;
    } exp_t;

    exp_t exp_q[$];
    bit   err_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 0;
    bit   acc_flag = 0;

    localparam logic [4:0] OH_L = 5'b00001;
    localparam logic [4:0] OH_N = 5'b00010;
    localparam logic [4:0] OH_S = 5'b00100;
    localparam logic [4:0] OH_W = 5'b01000;
    localparam logic [4:0] OH_E = 5'b10000;

    input_route_ctrl #(
        .FLIT_WIDTH(FW), .N_VIRT_CHN(2), .X_W(2), .Y_W(2),
        .ROUTER_X_ID(1), .ROUTER_Y_ID(1)
    ) dut (
        .clk(clk), .arst(arst), .fdata_i(fdata_i), .vc_id_i(vc_id_i),
        .valid_i(valid_i), .ready_o(ready_o), .fdata_o(fdata_o),
        .vc_id_o(vc_id_o), .valid_o(valid_o), .ready_i(ready_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [1:0] x,
                                         input logic [1:0] y, input logic [27:0] p);
        return {t, x, y, p};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Record whether the DUT took a flit on this edge
    always @(posedge clk) acc_flag <= valid_i && ready_o && !arst;

    // Monitor: score err_o after every accept and each delivered flit
    always @(negedge clk) begin
        if (mon_en) begin
            if (acc_flag) begin
                if (err_q.size() == 0) begin
                    check("err_q_underflow", 1, 0);
                end else begin
                    check("err_o", {63'd0, err_o}, {63'd0, err_q.pop_front()});
                end
            end else begin
                check("err_o_idle", {63'd0, err_o}, 64'd0);
            end
            if ((valid_o & ready_i) != 5'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_flit", {59'd0, valid_o}, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("valid_o", {59'd0, valid_o}, {59'd0, e.v});
                    check("fdata_o", {30'd0, fdata_o}, {30'd0, e.d});
                    check("vc_id_o", {63'd0, vc_id_o}, {63'd0, e.vc});
                end
            end
        end
    end

    task automatic send(input logic [FW-1:0] f, input logic [0:0] vc,
                        input bit outp, input logic [4:0] oh, input bit e);
        int n = 0;
        fdata_i = f;
        vc_id_i = vc;
        valid_i = 1'b1;
        #1;
        while (!ready_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ready_o) begin
            check("send_timeout", 0, 1);
            valid_i = 1'b0;
            return;
        end
        if (outp) exp_q.push_back('{v: oh, d: f, vc: vc});
        err_q.push_back(e);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] f0;
        logic [FW-1:0] f1;
        arst = 1'b1;
        valid_i = 1'b0;
        fdata_i = '0;
        vc_id_i = '0;
        ready_i = 5'h1F;
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0;
        check("rst_valid_o", {59'd0, valid_o}, 64'd0);
        check("rst_ready_o", {63'd0, ready_o}, 64'd1);
        check("rst_err_o", {63'd0, err_o}, 64'd0);
        check("rst_fdata_o", {30'd0, fdata_o}, 64'd0);
        check("rst_vc_id_o", {63'd0, vc_id_o}, 64'd0);
        mon_en = 1;

        // single-flit packet east
        send(mk(2'b11, 2'd3, 2'd1, 28'h0000A01), 1'b0, 1, OH_E, 0);

        // HEAD/BODY/TAIL north on VC1, then orphan BODY
        send(mk(2'b00, 2'd1, 2'd0, 28'h0000B01), 1'b1, 1, OH_N, 0);
        send(mk(2'b01, 2'd0, 2'd0, 28'h0000B02), 1'b1, 1, OH_N, 0);
        send(mk(2'b10, 2'd0, 2'd0, 28'h0000B03), 1'b1, 1, OH_N, 0);
        send(mk(2'b01, 2'd0, 2'd0, 28'h0000B04), 1'b1, 0, OH_L, 1);

        // local delivery stalled for 3 cycles, next flit accepted on release
        ready_i = 5'h1E;
        f0 = mk(2'b11, 2'd1, 2'd1, 28'h0000C01);
        f1 = mk(2'b11, 2'd1, 2'd2, 28'h0000C02);
        send(f0, 1'b0, 1, OH_L, 0);
        fdata_i = f1;
        vc_id_i = 1'b1;
        valid_i = 1'b1;
        repeat (3) begin
            check("stall_ready_o", {63'd0, ready_o}, 64'd0);
            check("stall_valid_o", {59'd0, valid_o}, {59'd0, OH_L});
            check("stall_fdata_o", {30'd0, fdata_o}, {30'd0, f0});
            @(posedge clk);
            #1;
        end
        ready_i = 5'h1F;
        #1;
        check("release_ready_o", {63'd0, ready_o}, 64'd1);
        exp_q.push_back('{v: OH_S, d: f1, vc: 1'b1});
        err_q.push_back(1'b0);
        @(posedge clk);
        #1;
        valid_i = 1'b0;

        // interleaved VCs: W, S, W, S, W, then both locks gone
        send(mk(2'b00, 2'd0, 2'd3, 28'h0000D01), 1'b0, 1, OH_W, 0);
        send(mk(2'b00, 2'd1, 2'd2, 28'h0000D02), 1'b1, 1, OH_S, 0);
        send(mk(2'b01, 2'd3, 2'd3, 28'h0000D03), 1'b0, 1, OH_W, 0);
        send(mk(2'b10, 2'd0, 2'd0, 28'h0000D04), 1'b1, 1, OH_S, 0);
        send(mk(2'b10, 2'd3, 2'd0, 28'h0000D05), 1'b0, 1, OH_W, 0);
        send(mk(2'b01, 2'd0, 2'd0, 28'h0000D06), 1'b0, 0, OH_L, 1);
        send(mk(2'b01, 2'd0, 2'd0, 28'h0000D07), 1'b1, 0, OH_L, 1);

        // second HEAD while locked replaces the route
        send(mk(2'b00, 2'd3, 2'd0, 28'h0000E01), 1'b0, 1, OH_E, 0);
        send(mk(2'b00, 2'd1, 2'd0, 28'h0000E02), 1'b0, 1, OH_N, 1);
        send(mk(2'b01, 2'd0, 2'd0, 28'h0000E03), 1'b0, 1, OH_N, 0);
        send(mk(2'b10, 2'd0, 2'd0, 28'h0000E04), 1'b0, 1, OH_N, 0);

        // reset with a held HEAD, then orphan TAIL
        ready_i = 5'h0F;
        f0 = mk(2'b00, 2'd3, 2'd1, 28'h0000F01);
        send(f0, 1'b0, 1, OH_E, 0);
        repeat (2) @(posedge clk);
        #1;
        check("held_valid_o", {59'd0, valid_o}, {59'd0, OH_E});
        check("held_fdata_o", {30'd0, fdata_o}, {30'd0, f0});
        arst = 1'b1;
        @(posedge clk);
        #1;
        arst = 1'b0;
        void'(exp_q.pop_back());
        check("midrst_valid_o", {59'd0, valid_o}, 64'd0);
        check("midrst_err_o", {63'd0, err_o}, 64'd0);
        check("midrst_ready_o", {63'd0, ready_o}, 64'd1);
        ready_i = 5'h1F;
        send(mk(2'b10, 2'd0, 2'd0, 28'h0000F02), 1'b0, 0, OH_L, 1);

        repeat (4) @(posedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);
        check("err_q_drained", err_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
